// File: rtl/br_multiport.sv
// br_multiport: parametrised register file with NRD combinational read ports,
// one synchronous write port, a hardwired zero register, optional same-cycle
// write-to-read bypass and a per-register pending (scoreboard) bitmap used by
// pipeline control to detect hazards on outstanding long-latency results.
module br_multiport #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic [AW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  input  logic                 we,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Next-state: write clears the pending bit, a mark to the same address wins.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and start from a
    // full default so that no path leaves a variable unassigned (no latch).
    regs_d = regs_q;
    pend_d = pend_q;
    // Enables are tested before the addresses are used, so an unknown
    // address with its enable low never touches state.
    if (we && (wa != '0)) begin
      regs_d[wa] = wd;
      pend_d[wa] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      pend_d[set_addr] = 1'b1;
    end
  end

  // State registers: asynchronous clear of every register and pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is deliberately reset because the register file
      // must read all-zero immediately on reset; that keeps it in flops
      // rather than a RAM macro, and sequential state uses non-blocking <=.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read ports: independent combinational muxes with zero-register forcing
  // and optional forwarding of the write in flight.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit;

    assign addr    = ra[i*AW +: AW];
    assign is_zero = (addr == '0);
    // Bypass is suppressed during reset so every port reads zero then.
    assign hit     = (BYPASS != 0) && rst_n && we && (wa == addr);

    assign rd[i*XLEN +: XLEN] = is_zero ? '0 :
                                hit     ? wd : regs_q[addr];
    assign rbusy[i]           = (is_zero || hit) ? 1'b0 : pend_q[addr];
  end

endmodule

// File: doc/br_multiport.md
# br_multiport

Parametrised successor to the rv32i register file (BR). Provides NRD combinational read ports, one synchronous write port, a hardwired zero register, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bitmap. The bitmap lets the pipeline control detect read-after-write hazards on outstanding loads. Sits in the data path between decode (read addresses, issue marking) and writeback (write port).

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of registers; power of two, ≥ 2. Address width AW = log2(NREG).
- NRD, 2: number of read ports, ≥ 1.
- BYPASS, 1: 1 forwards the current-cycle write data to matching read ports; 0 means a write is visible only after the clock edge.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all registers and all pending bits.
- ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rbusy  out  NRD  pending bit of the register addressed by port i.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- we  in  1  write enable.
- set_en  in  1  mark register set_addr as pending (issue of an instruction with a long-latency result).
- set_addr  in  AW  register to mark.

## Operation
- Storage: NREG x XLEN registers. Register 0 always reads 0, is never written, and is never pending.
- Write: on a rising clk edge with we=1 and wa≠0, reg[wa] ← wd and pend[wa] ← 0. A write with wa=0 is ignored entirely.
- Mark: on a rising clk edge with set_en=1 and set_addr≠0, pend[set_addr] ← 1.
- Mark and write in the same cycle to the same address: the mark wins. The register takes wd and the pending bit ends at 1, because a new producer has been issued. Different addresses are independent.
- Read (combinational, each port independent, any ports may share an address):
  - ra_i = 0 → rd_i = 0, rbusy_i = 0.
  - BYPASS=1, we=1, wa=ra_i≠0 → rd_i = wd, rbusy_i = 0. The arriving write resolves the hazard.
  - otherwise → rd_i = reg[ra_i], rbusy_i = pend[ra_i].
- set_en does not affect rbusy until after the clock edge. There is no bypass for marks.
- No arithmetic. Addresses are always in range because NREG = 2^AW.

## Timing
- Read latency 0 cycles (combinational from ra, and from wa/wd/we when BYPASS=1).
- Write and mark latency 1 edge. With BYPASS=0, data read in the write cycle is the old value; the new value appears after the edge.
- Reset: asserting rst_n low immediately clears all registers and pending bits, with no clock required, including mid-write or mid-mark. While rst_n=0, every rd_i = 0, every rbusy_i = 0, and edges are ignored.
- Deassertion: the first edge with rst_n=1 performs normal writes and marks.
- X on ra or wa while the corresponding enable is low must not corrupt state.

## Test plan
- Reset then read all: rst_n=0 pulse, then sweep ra over 0..NREG-1 on every port → all rd = 0 and all rbusy = 0.
- Write/readback, NRD=2: write 32'h12→x10, 32'hF00F→x5, 32'hABC→x21 on consecutive edges, then read pairs → x10=12, x5=F00F, x21=ABC, all others 0. A write of 32'hDEAD to x0 leaves x0 reading 0.
- Bypass:
  - BYPASS=1: we=1, wa=7, wd=32'h55, ra0=7 before the edge → rd0 = 55 in the same cycle.
  - BYPASS=0: same stimulus → rd0 = old value (0) before the edge and 55 after it.
- Scoreboard:
  - set_en, set_addr=9 → rbusy for ra=9 rises after the edge.
  - A later write of 32'h77 to x9 → rbusy = 0 and rd = 77 after the edge; with BYPASS=1, rbusy = 0 and rd = 77 already in the write cycle.
- Simultaneous mark and write to x3 → reg[3] = wd and pend[3] = 1 after the edge. set_addr=0 → no pending bit is set.
- Asynchronous reset mid-operation: with x4 = 32'hAA and pend[4] = 1, pull rst_n low between clock edges → rd = 0 and rbusy = 0 immediately, before the next edge.
